// File: rtl/ldst_access_arbiter_pkg.sv
// Shared load/store types: address/stride words and the arbiter state.
// Also holds the strided address step used by the access sequencer.
package ldst_access_arbiter_pkg;

    localparam int ADDR_W   = 16;
    localparam int STRIDE_W = 12;

    typedef logic [ADDR_W-1:0]          address_t;
    typedef logic signed [STRIDE_W-1:0] stride_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ISSUE,
        DRAIN,
        TERM
    } ldst_arb_state_t;

    // Wraps modulo 2^ADDR_W; the stride is sign-extended first.
    function automatic address_t addr_step(
        input address_t a,
        input stride_t  s
    );
        return a + address_t'({{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the
// pointer, searching cyclically.
module rr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   I_Req,
    input  logic [WIDTH_REQ-1:0] I_Ptr,
    output logic [NUM_REQ-1:0]   O_Grant,
    output logic [WIDTH_REQ-1:0] O_Index
);

    logic                 found;
    logic [WIDTH_REQ-1:0] idx;

    always_comb begin
        O_Grant = '0;
        O_Index = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = WIDTH_REQ'((int'(I_Ptr) + i) % NUM_REQ);
            if (!found && I_Req[idx]) begin
                found        = 1'b1;
                O_Grant[idx] = 1'b1;
                O_Index      = idx;
            end
        end
    end

endmodule

// File: rtl/ldst_access_arbiter.sv
// Shares one data-memory port among ldst units: round-robin grant,
// strided address generation, load return steering, end-of-access pulse.
module ldst_access_arbiter
    import ldst_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      I_Stall,
    input  logic [NUM_REQ-1:0]        I_Req,
    input  logic [NUM_REQ-1:0]        I_Store,
    input  address_t [NUM_REQ-1:0]    I_Length,
    input  stride_t  [NUM_REQ-1:0]    I_Stride,
    input  address_t [NUM_REQ-1:0]    I_Base,
    input  logic [NUM_REQ-1:0]        I_Ready,
    output logic [NUM_REQ-1:0]        O_Access_Grant,
    output logic [NUM_REQ-1:0]        O_Commit_Grant,
    output logic [NUM_REQ-1:0]        O_Valid,
    output logic [NUM_REQ-1:0]        O_Term,
    output logic                      O_Mem_Req,
    output logic                      O_Mem_We,
    output address_t                  O_Mem_Addr,
    input  logic                      I_Mem_Ack,
    input  logic                      I_Mem_RValid,
    output logic                      O_Busy
);

    ldst_arb_state_t      state_q;
    logic [WIDTH_REQ-1:0] sel_q;
    logic [WIDTH_REQ-1:0] ptr_q;
    logic                 store_q;
    address_t             len_q;
    stride_t              stride_q;
    address_t             base_q;
    address_t             addr_q;
    address_t             issue_cnt_q;
    address_t             resp_cnt_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [WIDTH_REQ-1:0] arb_idx;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_REQ (WIDTH_REQ)
    ) u_rr (
        .I_Req   (I_Req),
        .I_Ptr   (ptr_q),
        .O_Grant (arb_grant),
        .O_Index (arb_idx)
    );

    logic               in_issue;
    logic               in_drain;
    logic               mem_req;
    logic               fire;
    logic               rsp;
    logic               last_issue;
    address_t           resp_next;
    logic [NUM_REQ-1:0] owner_oh;

    assign in_issue   = (state_q == ISSUE);
    assign in_drain   = (state_q == DRAIN);
    assign mem_req    = in_issue && !I_Stall && I_Ready[sel_q];
    assign fire       = mem_req && I_Mem_Ack;
    // Load returns are counted regardless of stall so none are lost.
    assign rsp        = (in_issue || in_drain) && !store_q && I_Mem_RValid;
    assign resp_next  = resp_cnt_q + address_t'(rsp);
    assign last_issue = (issue_cnt_q == len_q - address_t'(1));
    assign owner_oh   = NUM_REQ'(1) << sel_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            store_q     <= 1'b0;
            len_q       <= '0;
            stride_q    <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            resp_cnt_q  <= '0;
        end else begin
            if (rsp) resp_cnt_q <= resp_next;
            if (!I_Stall) begin
                unique case (state_q)
                    IDLE: begin
                        if (|I_Req) begin
                            sel_q    <= arb_idx;
                            store_q  <= |(I_Store & arb_grant);
                            len_q    <= I_Length[arb_idx];
                            stride_q <= I_Stride[arb_idx];
                            base_q   <= I_Base[arb_idx];
                            state_q  <= GRANT;
                        end
                    end
                    GRANT: begin
                        addr_q      <= base_q;
                        issue_cnt_q <= '0;
                        resp_cnt_q  <= '0;
                        state_q     <= (len_q == '0) ? TERM : ISSUE;
                    end
                    ISSUE: begin
                        if (fire) begin
                            addr_q      <= addr_step(addr_q, stride_q);
                            issue_cnt_q <= issue_cnt_q + address_t'(1);
                            if (last_issue) begin
                                if (store_q || resp_next == len_q)
                                    state_q <= TERM;
                                else
                                    state_q <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (resp_next == len_q) state_q <= TERM;
                    end
                    TERM: begin
                        ptr_q   <= (sel_q == WIDTH_REQ'(NUM_REQ-1)) ?
                                   '0 : sel_q + 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign O_Access_Grant = (state_q == GRANT) ? owner_oh : '0;
    assign O_Commit_Grant = (state_q == GRANT) ? owner_oh : '0;
    assign O_Term         = (state_q == TERM)  ? owner_oh : '0;
    assign O_Valid        = rsp ? owner_oh : '0;
    assign O_Mem_Req      = mem_req;
    assign O_Mem_We       = in_issue && store_q;
    assign O_Mem_Addr     = addr_q;
    assign O_Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ldst_access_arbiter.sv
// Directed bench for ldst_access_arbiter: vector table of single
// accesses plus round-robin, backpressure, stall and reset sequences.
module tb_ldst_access_arbiter;
    import ldst_access_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic             stall = 1'b0;
    logic [1:0]       req = '0;
    logic [1:0]       store_v = '0;
    address_t [1:0]   len_v = '0;
    stride_t  [1:0]   stride_v = '0;
    address_t [1:0]   base_v = '0;
    logic [1:0]       ready = 2'b11;
    logic             mem_ack = 1'b1;
    logic             mem_rvalid = 1'b0;
    logic [1:0]       acc_g, com_g, valid, term;
    logic             mem_req, mem_we, busy;
    address_t         mem_addr;

    ldst_access_arbiter #(.NUM_REQ(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .I_Stall        (stall),
        .I_Req          (req),
        .I_Store        (store_v),
        .I_Length       (len_v),
        .I_Stride       (stride_v),
        .I_Base         (base_v),
        .I_Ready        (ready),
        .O_Access_Grant (acc_g),
        .O_Commit_Grant (com_g),
        .O_Valid        (valid),
        .O_Term         (term),
        .O_Mem_Req      (mem_req),
        .O_Mem_We       (mem_we),
        .O_Mem_Addr     (mem_addr),
        .I_Mem_Ack      (mem_ack),
        .I_Mem_RValid   (mem_rvalid),
        .O_Busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor state, sampled on the falling edge.
    int       g_cnt[2], v_cnt[2], t_cnt[2];
    int       req_cyc, noack_cyc, stall_req, stall_valid;
    int       onehot_bad, ready_bad, hold_bad;
    logic     we_any, hold_pend, fire_s;
    address_t hold_addr, stall_addr;
    address_t addr_log[$];
    int       gorder[$];
    int       exp_owner = 0;

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            g_cnt[i] = 0; v_cnt[i] = 0; t_cnt[i] = 0;
        end
        req_cyc = 0; noack_cyc = 0; stall_req = 0; stall_valid = 0;
        onehot_bad = 0; ready_bad = 0; hold_bad = 0;
        we_any = 1'b0; hold_pend = 1'b0; stall_addr = '0;
        addr_log.delete();
        gorder.delete();
    endtask

    initial begin
        clr();
        fire_s = 1'b0;
    end

    always @(negedge clock) begin
        fire_s = mem_req & mem_ack & ~mem_we;
        for (int i = 0; i < 2; i++) begin
            g_cnt[i] += int'(acc_g[i]);
            v_cnt[i] += int'(valid[i]);
            t_cnt[i] += int'(term[i]);
            if (acc_g[i]) gorder.push_back(i);
        end
        if (acc_g != com_g || $countones(acc_g) > 1 ||
            $countones(valid) > 1 || $countones(term) > 1)
            onehot_bad++;
        if (mem_req) begin
            req_cyc++;
            if (mem_we) we_any = 1'b1;
            if (!ready[exp_owner]) ready_bad++;
            if (stall) stall_req++;
            if (hold_pend && mem_addr != hold_addr) hold_bad++;
            if (mem_ack) addr_log.push_back(mem_addr);
            else noack_cyc++;
        end
        hold_pend = mem_req & ~mem_ack;
        hold_addr = mem_addr;
        if (stall) begin
            stall_valid += int'(|valid);
            stall_addr = mem_addr;
        end
    end

    // Memory model: load data returns two cycles after acceptance.
    logic rv_d1 = 1'b0, rv_d2 = 1'b0;
    always @(posedge clock) begin
        #1;
        rv_d2 = rv_d1;
        rv_d1 = fire_s;
        mem_rvalid = rv_d2;
    end

    task automatic run(input int own, input logic st, input int ln,
                       input int sd, input int bs,
                       input logic [39:0] ackp, input logic [39:0] rdyp,
                       input logic [39:0] stlp, input int rst_at);
        clr();
        exp_owner = own;
        store_v[own] = st;
        len_v[own] = address_t'(ln);
        stride_v[own] = stride_t'(sd);
        base_v[own] = address_t'(bs);
        for (int k = 0; k < 60; k++) begin
            @(posedge clock); #1;
            if (rst_at >= 0) begin
                if (k == rst_at + 1) begin
                    reset = 1'b0;
                    break;
                end
                reset = (k == rst_at);
            end else if (t_cnt[0] + t_cnt[1] > 0) begin
                break;
            end
            if (k == 0) req[own] = 1'b1;
            else if (g_cnt[own] > 0) req[own] = 1'b0;
            mem_ack = ackp[k];
            ready = {2{rdyp[k]}};
            stall = stlp[k];
        end
        mem_ack = 1'b1; ready = 2'b11; stall = 1'b0; req = '0;
    endtask

    typedef struct {
        int             own;
        logic           st;
        int             ln;
        int             sd;
        int             bs;
        address_t [3:0] ea;
        int             nv;
    } vec_t;

    function automatic vec_t mkv(int o, logic s, int l, int sd, int b,
                                 int a0, int a1, int a2, int nv);
        vec_t v;
        v.own = o; v.st = s; v.ln = l; v.sd = sd; v.bs = b; v.nv = nv;
        v.ea[0] = address_t'(a0);
        v.ea[1] = address_t'(a1);
        v.ea[2] = address_t'(a2);
        v.ea[3] = '0;
        return v;
    endfunction

    initial begin
        vec_t        vt[6];
        logic [39:0] ones, zeros, ap, rp, sp;
        int          o, vp;
        string       nm;

        vt[0] = mkv(0, 1'b0, 3, 4,     'h10,   'h10,   'h14,   'h18, 3);
        vt[1] = mkv(1, 1'b1, 3, -4,    'h4,    'h4,    'h0,    'hFFFC, 0);
        vt[2] = mkv(1, 1'b0, 3, 1,     'hFFFE, 'hFFFE, 'hFFFF, 'h0, 3);
        vt[3] = mkv(0, 1'b1, 2, 'h7F0, 'h100,  'h100,  'h8F0,  'h0, 0);
        vt[4] = mkv(1, 1'b0, 2, -2048, 'h800,  'h800,  'h0,    'h0, 2);
        vt[5] = mkv(0, 1'b0, 0, 4,     'h30,   'h0,    'h0,    'h0, 0);
        ones = '1; zeros = '0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_grants", {acc_g, com_g}, 0);
        chk("rst_valid_term", {valid, term}, 0);
        chk("rst_mem", {mem_req, mem_we, busy}, 0);
        chk("rst_addr", mem_addr, 0);

        for (int i = 0; i < 6; i++) begin
            o = vt[i].own;
            run(o, vt[i].st, vt[i].ln, vt[i].sd, vt[i].bs,
                ones, ones, zeros, -1);
            nm = $sformatf("v%0d", i);
            chk({nm, "_term"}, t_cnt[o], 1);
            chk({nm, "_grant"}, g_cnt[o], 1);
            chk({nm, "_other"}, g_cnt[1-o] + v_cnt[1-o] + t_cnt[1-o], 0);
            chk({nm, "_nacc"}, addr_log.size(), vt[i].ln);
            for (int j = 0; j < vt[i].ln; j++)
                chk($sformatf("%s_addr%0d", nm, j),
                    j < addr_log.size() ? addr_log[j] : 32'hDEAD,
                    vt[i].ea[j]);
            chk({nm, "_valid"}, v_cnt[o], vt[i].nv);
            chk({nm, "_we"}, we_any, vt[i].st && vt[i].ln > 0);
            chk({nm, "_onehot"}, onehot_bad, 0);
        end

        // Round-robin with both requesters held.
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        clr();
        exp_owner = 0;
        store_v = '0;
        len_v[0] = 16'd1; len_v[1] = 16'd1;
        stride_v[0] = 12'd1; stride_v[1] = 12'd1;
        base_v[0] = 16'hA0; base_v[1] = 16'hB0;
        req = 2'b11;
        for (int k = 0; k < 150; k++) begin
            @(posedge clock); #1;
            if (t_cnt[0] + t_cnt[1] >= 4) break;
        end
        req = '0;
        chk("rr_ngrant", gorder.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i),
                i < gorder.size() ? gorder[i] : 32'hDEAD, i % 2);
            chk($sformatf("rr_addr%0d", i),
                i < addr_log.size() ? addr_log[i] : 32'hDEAD,
                (i % 2) ? 32'hB0 : 32'hA0);
        end
        chk("rr_term", {t_cnt[0][7:0], t_cnt[1][7:0]}, 16'h0202);
        chk("rr_valid", {v_cnt[0][7:0], v_cnt[1][7:0]}, 16'h0202);
        chk("rr_onehot", onehot_bad, 0);

        // Backpressure: two un-acked cycles, then one not-ready cycle.
        ap = '1; ap[3] = 1'b0; ap[4] = 1'b0;
        rp = '1; rp[6] = 1'b0;
        run(0, 1'b0, 4, 8, 'h20, ap, rp, zeros, -1);
        chk("bp_nacc", addr_log.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("bp_addr%0d", j),
                j < addr_log.size() ? addr_log[j] : 32'hDEAD,
                32'h20 + 8 * j);
        chk("bp_req_cycles", req_cyc, 6);
        chk("bp_noack", noack_cyc, 2);
        chk("bp_hold", hold_bad, 0);
        chk("bp_ready", ready_bad, 0);
        chk("bp_valid", v_cnt[0], 4);
        chk("bp_term", t_cnt[0], 1);

        // Stall three cycles mid-issue; returns still counted.
        sp = '0; sp[4] = 1'b1; sp[5] = 1'b1; sp[6] = 1'b1;
        run(0, 1'b0, 3, 2, 'h40, ones, ones, sp, -1);
        chk("st_nacc", addr_log.size(), 3);
        for (int j = 0; j < 3; j++)
            chk($sformatf("st_addr%0d", j),
                j < addr_log.size() ? addr_log[j] : 32'hDEAD,
                32'h40 + 2 * j);
        chk("st_req_in_stall", stall_req, 0);
        chk("st_valid_in_stall", stall_valid, 2);
        chk("st_addr_frozen", stall_addr, 16'h44);
        chk("st_valid", v_cnt[0], 3);
        chk("st_term", t_cnt[0], 1);

        // Reset during issue aborts without a termination pulse.
        run(1, 1'b0, 5, 1, 'h0, ones, ones, zeros, 5);
        @(negedge clock);
        chk("ra_outs", {acc_g, com_g, valid, term, mem_req, mem_we, busy}, 0);
        chk("ra_addr", mem_addr, 0);
        chk("ra_valid_before", v_cnt[1], 2);
        vp = v_cnt[0] + v_cnt[1];
        repeat (8) @(negedge clock);
        chk("ra_late_rvalid_ignored", v_cnt[0] + v_cnt[1], vp);
        chk("ra_no_term", t_cnt[0] + t_cnt[1], 0);
        chk("ra_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
